usb_fs_tx_encoder: RTL and testbench

Full-speed USB line transmitter: accepts packet bytes over a valid/ready stream and drives the D+/D− line with SYNC, NRZI-encoded bit-stuffed data and EOP at 12 Mbit/s, derived from a faster system clock. It is the transmit half of a device or host PHY. It sits between a packet assembler and the tristate line drivers.

---
 rtl/usb_fs_tx_encoder.sv | 141 ++++++++++++++
 tb/tb_usb_fs_tx_encoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_tx_encoder.sv
// Full-speed USB transmitter: SYNC, NRZI-encoded bit-stuffed payload and EOP on D+/D-.
// All outputs are registered; the line only changes on the bit strobe.
module usb_fs_tx_encoder #(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       usb_dp_out,
  output logic       usb_dn_out,
  output logic       usb_oe
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntPre  = CntW'(CLK_DIV - 2);

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
    StEop1,
    StEop2,
    StEopJ
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      byte_q;
  logic [2:0]      idx_q;
  logic [2:0]      ones_q;
  logic            dp_q, dn_q, oe_q, ready_q, busy_q;

  logic       strobe, stuff_due, last_bit, load, emit_bit, ready_set;
  logic [2:0] next_idx;

  // idx_q is the data bit most recently put on the line; a stuff bit occupies
  // a bit time without advancing it, which delays the byte boundary.
  always_comb begin
    strobe    = (cnt_q == CntLast);
    stuff_due = (ones_q == 3'd6);
    last_bit  = (idx_q == 3'd7);
    load      = ready_q && tx_valid;
    next_idx  = idx_q + 3'd1;
    emit_bit  = stuff_due ? 1'b0 : (load ? tx_data[0] : byte_q[next_idx]);
    // Ready is registered, so it is raised one cycle ahead of the boundary strobe.
    ready_set = (state_q inside {StSync, StData}) && (cnt_q == CntPre) && last_bit &&
                !stuff_due && tx_valid;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      byte_q  <= '0;
      idx_q   <= '0;
      ones_q  <= '0;
      dp_q    <= 1'b1;
      dn_q    <= 1'b0;
      oe_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= ready_set;
      if (state_q == StIdle) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= strobe ? '0 : cnt_q + CntW'(1);
      end
      case (state_q)
        StIdle: begin
          if (tx_valid) begin
            state_q <= StSync;
            oe_q    <= 1'b1;
            busy_q  <= 1'b1;
            byte_q  <= 8'h80;
            idx_q   <= '0;
            ones_q  <= '0;
            // SYNC bit 0 is a zero, so the first symbol is already the toggle to K.
            dp_q    <= 1'b0;
            dn_q    <= 1'b1;
          end
        end
        StSync, StData: begin
          if (strobe) begin
            if (stuff_due || !last_bit || load) begin
              if (emit_bit) begin
                ones_q <= ones_q + 3'd1;
              end else begin
                ones_q <= '0;
                dp_q   <= ~dp_q;
                dn_q   <= ~dn_q;
              end
              if (!stuff_due) begin
                idx_q <= load ? 3'd0 : next_idx;
              end
              if (load) begin
                byte_q  <= tx_data;
                state_q <= StData;
              end
            end else begin
              state_q <= StEop1;
              dp_q    <= 1'b0;
              dn_q    <= 1'b0;
            end
          end
        end
        StEop1: begin
          if (strobe) begin
            state_q <= StEop2;
          end
        end
        StEop2: begin
          if (strobe) begin
            state_q <= StEopJ;
            dp_q    <= 1'b1;
            dn_q    <= 1'b0;
          end
        end
        StEopJ: begin
          if (strobe) begin
            state_q <= StIdle;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_ready   = ready_q;
  assign tx_busy    = busy_q;
  assign usb_dp_out = dp_q;
  assign usb_dn_out = dn_q;
  assign usb_oe     = oe_q;

endmodule

// File: tb/tb_usb_fs_tx_encoder.sv
// Directed bench for usb_fs_tx_encoder: a reference encoder fills symbol/ready scoreboards,
// and a NRZI decoder with destuffing recovers the bytes from the sampled line.
module tb_usb_fs_tx_encoder;

  localparam int unsigned D = 5;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, dp, dn, oe;

  int checks = 0;
  int failures = 0;

  logic [1:0] exp_sym_q[$];
  int         exp_rdy_q[$];
  logic [7:0] pkt[$];
  logic [1:0] seen[$];

  usb_fs_tx_encoder #(.CLK_DIV(D)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_busy   (tx_busy),
    .usb_dp_out(dp),
    .usb_dn_out(dn),
    .usb_oe    (oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference line model: J=2'b10, K=2'b01, SE0=2'b00 as {dp,dn}.
  task automatic build_expected(output int nsym);
    logic       lvl;
    int         ones;
    logic [7:0] b;
    lvl  = 1'b1;
    ones = 0;
    nsym = 0;
    exp_sym_q.delete();
    exp_rdy_q.delete();
    for (int i = -1; i < pkt.size(); i++) begin
      b = (i < 0) ? 8'h80 : pkt[i];
      for (int j = 0; j < 8; j++) begin
        if (b[j]) ones++;
        else begin
          lvl  = ~lvl;
          ones = 0;
        end
        exp_sym_q.push_back(lvl ? 2'b10 : 2'b01);
        nsym++;
        if (ones == 6) begin
          lvl  = ~lvl;
          ones = 0;
          exp_sym_q.push_back(lvl ? 2'b10 : 2'b01);
          nsym++;
        end
      end
      if (i + 1 < pkt.size()) exp_rdy_q.push_back(nsym * D - 1);
    end
    exp_sym_q.push_back(2'b00);
    exp_sym_q.push_back(2'b00);
    exp_sym_q.push_back(2'b10);
    nsym += 3;
  endtask

  task automatic decode_check(input string name);
    logic       prev, cur, bitv;
    int         ones, nbits;
    logic [7:0] acc;
    logic [7:0] got[$];
    prev  = 1'b1;
    ones  = 0;
    nbits = 0;
    acc   = 8'h00;
    for (int i = 0; i < seen.size(); i++) begin
      if (seen[i] == 2'b00) break;
      cur  = seen[i][1];
      bitv = (cur == prev);
      prev = cur;
      if (ones == 6) begin
        check({name, " stuff_zero"}, 32'(bitv), 32'd0);
        ones = 0;
        continue;
      end
      ones = bitv ? ones + 1 : 0;
      acc  = {bitv, acc[7:1]};
      nbits++;
      if (nbits % 8 == 0) got.push_back(acc);
    end
    check({name, " dec_count"}, got.size(), pkt.size() + 1);
    if (got.size() > 0) check({name, " dec_sync"}, got[0], 8'h80);
    for (int i = 0; i < pkt.size() && i + 1 < got.size(); i++)
      check({name, " dec_byte"}, got[i+1], pkt[i]);
  endtask

  task automatic run_packet(input string name, input int drop_at);
    int nsym, k, sent, rdy_k;
    bit pend;
    build_expected(nsym);
    seen.delete();
    sent = 0;
    pend = 1'b0;
    @(negedge clk);
    tx_data  = (pkt.size() > 0) ? pkt[0] : 8'h00;
    tx_valid = 1'b1;
    k = 0;
    while (!oe && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({name, " oe_rise"}, 32'(oe), 32'd1);
    check({name, " busy_rise"}, 32'(tx_busy), 32'd1);
    k = 0;
    while (oe && k < nsym * D + 20) begin
      if (pend) begin
        pend = 1'b0;
        sent++;
        if (sent < pkt.size()) tx_data = pkt[sent];
        else tx_valid = 1'b0;
      end
      if (drop_at >= 0 && k == drop_at) tx_valid = 1'b0;
      if (tx_ready) begin
        rdy_k = (exp_rdy_q.size() > 0) ? exp_rdy_q.pop_front() : -1;
        check({name, " ready_cycle"}, k, rdy_k);
        pend = 1'b1;
      end
      if (k % D == D / 2) begin
        seen.push_back({dp, dn});
        if (exp_sym_q.size() > 0) check({name, " line"}, {dp, dn}, exp_sym_q.pop_front());
      end
      @(negedge clk);
      k++;
    end
    tx_valid = 1'b0;
    check({name, " oe_len"}, k, nsym * D);
    check({name, " sym_left"}, exp_sym_q.size(), 0);
    check({name, " ready_left"}, exp_rdy_q.size(), 0);
    check({name, " busy_end"}, 32'(tx_busy), 32'd0);
    check({name, " idle_j"}, {dp, dn}, 2'b10);
    decode_check(name);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " dp"}, 32'(dp), 32'd1);
    check({name, " dn"}, 32'(dn), 32'd0);
    check({name, " oe"}, 32'(oe), 32'd0);
    check({name, " ready"}, 32'(tx_ready), 32'd0);
    check({name, " busy"}, 32'(tx_busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle");

    pkt = '{8'h00};
    run_packet("b00", -1);
    pkt = '{8'hFF};
    run_packet("bFF", -1);
    pkt = '{8'h01, 8'h02};
    run_packet("b01_02", -1);
    pkt = '{};
    run_packet("zero_len", 10);
    pkt = '{8'h7E, 8'h7E, 8'hFF};
    run_packet("stuff_span", -1);

    // Abort a packet in the middle of DATA with an asynchronous reset.
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    repeat (60) @(negedge clk);
    check("abort in_data oe", 32'(oe), 32'd1);
    #2 nreset = 1'b0;
    #1;
    check_reset_outputs("abort");
    tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("abort_hold");
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    pkt = '{8'h00};
    run_packet("after_abort", -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
